// File: rtl/csr_pkg.sv
// Shared types and constants for the machine-mode CSR file.
package csr_pkg;

    typedef enum logic [1:0] {
        READ_ONLY = 2'd0,
        WRITE     = 2'd1,
        SET       = 2'd2,
        CLEAR     = 2'd3
    } csr_access_t;

    typedef enum logic [11:0] {
        CSR_MSTATUS       = 12'h300,
        CSR_MISA          = 12'h301,
        CSR_MIE           = 12'h304,
        CSR_MTVEC         = 12'h305,
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MSCRATCH      = 12'h340,
        CSR_MEPC          = 12'h341,
        CSR_MCAUSE        = 12'h342,
        CSR_MTVAL         = 12'h343,
        CSR_MIP           = 12'h344,
        CSR_MCYCLE        = 12'hB00,
        CSR_MINSTRET      = 12'hB02,
        CSR_MCYCLEH       = 12'hB80,
        CSR_MINSTRETH     = 12'hB82,
        CSR_MVENDORID     = 12'hF11,
        CSR_MARCHID       = 12'hF12,
        CSR_MIMPID        = 12'hF13,
        CSR_MHARTID       = 12'hF14
    } csr_id_t;

    localparam logic [30:0] CAUSE_MSI        = 31'd3;
    localparam logic [30:0] CAUSE_MTI        = 31'd7;
    localparam logic [30:0] CAUSE_MEI        = 31'd11;
    localparam logic [30:0] CAUSE_LOCAL_BASE = 31'd16;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

endpackage

// File: rtl/csr_file_if.sv
// CSR instruction access port between execute stage and CSR file.
interface csr_file_if;
    import csr_pkg::*;

    logic [11:0] csr_id;
    csr_access_t access_type;
    logic [31:0] in;
    logic [31:0] out;
    logic        illegal;

    modport master (
        output csr_id, access_type, in,
        input  out, illegal
    );

    modport slave (
        input  csr_id, access_type, in,
        output out, illegal
    );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit counter with independently writable halves.
module csr_counter64 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);
    // A half-write holds the other half and suppresses the carry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   value <= '0;
        else if (wr_lo) value[31:0] <= wdata;
        else if (wr_hi) value[63:32] <= wdata;
        else if (inc)   value <= value + 64'd1;
    end
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap state, interrupts, counters.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID       = 32'd0,
    parameter int          NUM_LOCAL_IRQ = 4,
    parameter bit          VECTORED_EN   = 1'b1,
    parameter bit          COUNTERS_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    csr_file_if.slave   bus,
    input  logic        external_interrupt,
    input  logic        timer_interrupt,
    input  logic        software_interrupt,
    input  logic [(NUM_LOCAL_IRQ > 0 ? NUM_LOCAL_IRQ : 1)-1:0] local_irq,
    input  logic        exception,
    input  logic [30:0] exception_cause,
    input  logic [31:0] trap_value,
    input  logic        handle_trap,
    input  logic        exit_trap,
    input  logic        instret,
    input  logic [31:0] current_pc,
    output logic [31:0] trap_pc,
    output logic [31:0] ret_pc,
    output logic        interrupted
);
    localparam logic [31:0] IRQ_MASK = 32'h0000_0888
        | (((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << 16);

    logic        st_mie, st_mpie, tvec_mode;
    logic        inh_cy, inh_ir;
    logic [29:0] tvec_base;
    logic [31:0] mie_q, mscratch, mepc, mcause, mtval;
    logic [31:0] mip, pend, rdata, wdata, tvec_addr;
    logic [63:0] cyc_raw, ins_raw, cyc, ins;
    logic [15:0] lirq;
    logic [30:0] lcause, tcause;
    logic        hit, ro, wr;

    if (NUM_LOCAL_IRQ > 0) begin : g_lirq
        assign lirq = 16'(local_irq);
    end else begin : g_nolirq
        assign lirq = '0;
    end

    assign mip = ({lirq, 16'b0}
        | {20'b0, external_interrupt, 3'b0, timer_interrupt,
           3'b0, software_interrupt, 3'b0}) & IRQ_MASK;
    assign pend = mip & mie_q;
    assign interrupted = st_mie & (|pend);

    assign cyc = COUNTERS_EN ? cyc_raw : '0;
    assign ins = COUNTERS_EN ? ins_raw : '0;

    always_comb begin
        rdata = '0;
        hit   = 1'b1;
        ro    = 1'b0;
        case (bus.csr_id)
            CSR_MSTATUS:
                rdata = {24'b0, st_mpie, 3'b0, st_mie, 3'b0};
            CSR_MISA: begin
                rdata = MISA_VALUE;
                ro    = 1'b1;
            end
            CSR_MIE:       rdata = mie_q;
            CSR_MIP:       rdata = mip;
            CSR_MTVEC:     rdata = {tvec_base, 1'b0, tvec_mode};
            CSR_MCOUNTINHIBIT:
                rdata = {29'b0, inh_ir, 1'b0, inh_cy};
            CSR_MSCRATCH:  rdata = mscratch;
            CSR_MEPC:      rdata = mepc;
            CSR_MCAUSE:    rdata = mcause;
            CSR_MTVAL:     rdata = mtval;
            CSR_MCYCLE:    rdata = cyc[31:0];
            CSR_MCYCLEH:   rdata = cyc[63:32];
            CSR_MINSTRET:  rdata = ins[31:0];
            CSR_MINSTRETH: rdata = ins[63:32];
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID:
                ro = 1'b1;
            CSR_MHARTID: begin
                rdata = HART_ID;
                ro    = 1'b1;
            end
            default: hit = 1'b0;
        endcase
    end

    assign bus.out     = rdata;
    assign bus.illegal = ~hit | (ro & (bus.access_type != READ_ONLY));

    always_comb begin
        wdata = bus.in;
        case (bus.access_type)
            SET:     wdata = rdata | bus.in;
            CLEAR:   wdata = rdata & ~bus.in;
            default: wdata = bus.in;
        endcase
    end

    // Trap entry and mret own the cycle; CSR writes lose to them.
    assign wr = (bus.access_type != READ_ONLY) & ~bus.illegal
              & ~handle_trap & ~exit_trap;

    always_comb begin
        lcause = '0;
        for (int i = 15; i >= 0; i--)
            if (pend[16+i]) lcause = CAUSE_LOCAL_BASE + 31'(i);
        tcause = lcause;
        if (exception)     tcause = exception_cause;
        else if (pend[11]) tcause = CAUSE_MEI;
        else if (pend[3])  tcause = CAUSE_MSI;
        else if (pend[7])  tcause = CAUSE_MTI;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_mie    <= 1'b0;
            st_mpie   <= 1'b0;
            mie_q     <= '0;
            tvec_base <= '0;
            tvec_mode <= 1'b0;
            inh_cy    <= 1'b0;
            inh_ir    <= 1'b0;
            mscratch  <= '0;
            mepc      <= '0;
            mcause    <= '0;
            mtval     <= '0;
        end else if (handle_trap) begin
            mepc    <= current_pc & 32'hFFFF_FFFC;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
            mtval   <= trap_value;
            mcause  <= {~exception, tcause};
        end else if (exit_trap) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (wr) begin
            case (bus.csr_id)
                CSR_MSTATUS: begin
                    st_mie  <= wdata[3];
                    st_mpie <= wdata[7];
                end
                CSR_MIE: mie_q <= wdata & IRQ_MASK;
                CSR_MTVEC: begin
                    tvec_base <= wdata[31:2];
                    if (VECTORED_EN && !wdata[1])
                        tvec_mode <= wdata[0];
                end
                CSR_MCOUNTINHIBIT: begin
                    inh_cy <= wdata[0];
                    inh_ir <= wdata[2];
                end
                CSR_MSCRATCH: mscratch <= wdata;
                CSR_MEPC:     mepc <= wdata & 32'hFFFF_FFFC;
                CSR_MCAUSE:   mcause <= wdata;
                CSR_MTVAL:    mtval <= wdata;
                default: ;
            endcase
        end
    end

    assign tvec_addr = {tvec_base, 2'b00};
    assign trap_pc = (tvec_mode && mcause[31])
        ? tvec_addr + {mcause[29:0], 2'b00} : tvec_addr;
    assign ret_pc = mepc;

    csr_counter64 u_mcycle (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (COUNTERS_EN & ~inh_cy),
        .wr_lo   (COUNTERS_EN & wr & (bus.csr_id == CSR_MCYCLE)),
        .wr_hi   (COUNTERS_EN & wr & (bus.csr_id == CSR_MCYCLEH)),
        .wdata   (wdata),
        .value   (cyc_raw)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (COUNTERS_EN & instret & ~inh_ir),
        .wr_lo   (COUNTERS_EN & wr & (bus.csr_id == CSR_MINSTRET)),
        .wr_hi   (COUNTERS_EN & wr & (bus.csr_id == CSR_MINSTRETH)),
        .wdata   (wdata),
        .value   (ins_raw)
    );
endmodule
